// File: rtl/inst_queue_issue.sv
// -----------------------------------------------------------------------------
// inst_queue_issue
//   In-order instruction buffer between the fetcher and the decoder. Fetched
//   {inst, pc, predicted-jump} entries are held in a circular FIFO. At most one
//   entry is issued per cycle, and only when the ROB and the unit that will
//   receive it (RS for ALU ops, LSB for loads/stores) both have room. A ROB
//   clear discards everything buffered.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global ready; when low, all state holds (strobe drops)
//   iIF_en/inst/pc/pd  push request from the fetcher
//   oIF_full           queue cannot accept a push this cycle (combinational)
//   iROB_full          ROB has no free entry
//   iRS_full           reservation station has no free entry
//   iLSB_full          load/store buffer has no free entry
//   iROB_clr           misprediction flush
//   oDEC_en            registered one-cycle issue strobe
//   oDEC_inst/pc/pd    issued entry (holds when no issue)
// -----------------------------------------------------------------------------
module inst_queue_issue #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        iIF_en,
   input  logic [31:0] iIF_inst,
   input  logic [31:0] iIF_pc,
   input  logic        iIF_pd,
   output logic        oIF_full,
   input  logic        iROB_full,
   input  logic        iRS_full,
   input  logic        iLSB_full,
   input  logic        iROB_clr,
   output logic        oDEC_en,
   output logic [31:0] oDEC_inst,
   output logic [31:0] oDEC_pc,
   output logic        oDEC_pd
);

   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic             pd_mem   [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   logic [31:0]      head_inst_p0;
   logic             head_mem_p0;
   logic             advance_p0;
   logic             push_p0;
   logic             issue_p0;

   // Loads and stores go to the LSB; every other opcode (unknown ones too)
   // goes to the RS and is turned into a NOP further down the pipe.
   function automatic logic is_mem_op(input logic [6:0] opcode);
      return (opcode == 7'b0000011) || (opcode == 7'b0100011);
   endfunction

   assign oIF_full     = (count == FULL_CNT);
   assign head_inst_p0 = inst_mem[head];
   assign head_mem_p0  = is_mem_op(head_inst_p0[6:0]);

   // Flush and !rdy both freeze pushes and issues for this edge.
   assign advance_p0 = !rst && !iROB_clr && rdy;
   // Full is judged on the pre-edge count, so an issue in the same cycle
   // does not open a slot for the push.
   assign push_p0    = advance_p0 && iIF_en && !oIF_full;
   // Head-of-line blocking: only the head is ever considered.
   assign issue_p0   = advance_p0 && (count != '0) && !iROB_full &&
                       (head_mem_p0 ? !iLSB_full : !iRS_full);

   // ---- stage p0 -> storage: write the pushed entry at tail ----
   always_ff @(posedge clk) begin
      if (push_p0) begin
         inst_mem[tail] <= iIF_inst;
         pc_mem[tail]   <= iIF_pc;
         pd_mem[tail]   <= iIF_pd;
      end
   end

   // ---- stage p0 -> p1: pointer/count update and issue register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         oDEC_en   <= 1'b0;
         oDEC_inst <= '0;
         oDEC_pc   <= '0;
         oDEC_pd   <= 1'b0;
      end else if (iROB_clr) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         oDEC_en <= 1'b0;
      end else if (!rdy) begin
         oDEC_en <= 1'b0;
      end else begin
         if (push_p0) begin
            tail <= tail + 1'b1;
         end
         if (issue_p0) begin
            oDEC_inst <= head_inst_p0;
            oDEC_pc   <= pc_mem[head];
            oDEC_pd   <= pd_mem[head];
            oDEC_en   <= 1'b1;
            head      <= head + 1'b1;
         end else begin
            oDEC_en <= 1'b0;
         end
         case ({push_p0, issue_p0})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: doc/inst_queue_issue.md
Name: inst_queue_issue

Overview:
- In-order instruction buffer and issue scheduler between the fetcher and the decoder.
- Queues fetched {inst, pc, predicted-jump} entries in a circular FIFO.
- Issues at most one entry per cycle to the decoder, and only when the ROB and the target reservation unit (RS or LSB) can accept it.
- Discards all buffered entries on a ROB clear (misprediction flush).

Parameters:
- DEPTH, 16, number of FIFO entries (power of two).
- PTR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state holds
- iIF_en  in  1  fetcher presents a valid instruction this cycle
- iIF_inst  in  32  instruction word
- iIF_pc  in  32  instruction PC
- iIF_pd  in  1  predicted-jump flag
- oIF_full  out  1  queue cannot accept a push this cycle
- iROB_full  in  1  ROB has no free entry
- iRS_full  in  1  reservation station has no free entry
- iLSB_full  in  1  load/store buffer has no free entry
- iROB_clr  in  1  flush request from ROB (misprediction)
- oDEC_en  out  1  registered one-cycle issue strobe to decoder
- oDEC_inst  out  32  issued instruction word
- oDEC_pc  out  32  issued PC
- oDEC_pd  out  1  issued predicted-jump flag

Behaviour:
- State: storage array[DEPTH], head, tail (PTR_W bits, wrap modulo DEPTH), count (PTR_W+1 bits).
- Reset (rst high at a clk edge): head=tail=count=0, oDEC_en=0, oDEC_inst=0, oDEC_pc=0, oDEC_pd=0. oIF_full=0 after reset.
- oIF_full is combinational: (count==DEPTH).
- Priority at each edge: rst > iROB_clr > !rdy > normal operation.
- Flush (iROB_clr=1, rdy ignored):
  - head=tail=count=0 and oDEC_en=0.
  - A push or issue presented in the same cycle is dropped.
- rdy=0: no push, no issue, pointers and outputs hold, except oDEC_en, which is forced to 0 (no repeated strobe).
- Push: taken when iIF_en && !oIF_full.
  - Writes {inst, pc, pd} at tail; tail+1 wraps.
  - A push while full is ignored and the fetcher must hold the instruction.
  - A push and an issue in the same cycle while full: the push is still refused (full is evaluated pre-edge).
- Issue class is decoded from head inst[6:0]:
  - 7'b0000011 and 7'b0100011 are class MEM.
  - All other opcodes are class ALU, including unknown opcodes, which are issued and become NOP downstream.
- Issue condition: count!=0 && !iROB_full && (MEM ? !iLSB_full : !iRS_full).
  - On issue: output registers load the head entry, oDEC_en=1, head+1 wraps.
  - Otherwise oDEC_en=0 and the data outputs hold their previous values.
- Issue is strictly in order: a blocked head blocks every younger entry, even when that entry's unit is free.
- Simultaneous push and issue (not full): count is unchanged.
- Empty queue: no bypass. A push in cycle k can issue at the edge ending cycle k+1, so oDEC_en is high in cycle k+2 at the earliest.
- Maximum throughput: one issue per cycle with no bubbles while downstream is free and the queue is non-empty.
- oDEC_en is high for exactly one cycle per issued entry. Each entry is issued exactly once.

Test Plan:
- Reset, then push one ADDI (inst=32'h00500093, pc=32'h0, pd=0) in cycle 1 -> oDEC_en=1 only in cycle 3, with oDEC_inst=32'h00500093 and oDEC_pc=0.
- Hold iROB_full=1 and push 17 instructions (pc=0,4,...,64) -> oIF_full=1 after 16 pushes and pc=64 is not stored. Release iROB_full -> 16 consecutive issue strobes with pc 0..60 in order, then oIF_full=0.
- Head is LW (opcode 0000011) with iLSB_full=1, iRS_full=0, next entry ADD -> no issue. Drop iLSB_full -> LW issues, then ADD issues on the next cycle.
- 5 entries queued, iROB_clr=1 for one cycle while iIF_en=1 -> oDEC_en=0 in the following cycle, queue empty, and the pushed instruction is discarded. A new push then issues with the 2-cycle latency.
- Continuous push/issue of 40 instructions with no stalls -> pointers wrap past 15 without loss. After the first issue, oDEC_en is high every cycle and PCs are strictly sequential.
- rdy=0 for 3 cycles mid-stream with 3 entries queued -> no strobe and count=3 held. After rdy=1, the 3 entries issue in order with no duplicate strobe.
